mutative_tag_array_nway: RTL and testbench
==========================================

Name: mutative_tag_array_nway

Overview:
- Parametrised multi-way successor to the single-way 128x21 tag SRAM model.
- Stores NUM_WAYS tags plus one valid bit per way per set, and supports per-way write masking.
- Compares the tags in hardware and returns a registered per-way hit vector.
- After reset it sweeps every set to clear it, so the cache controller never sees stale or X tags. It sits between the mutative cache controller and its data array.

Parameters:
- DATA_WIDTH, 21, tag width per way in bits.
- ADDR_WIDTH, 7, set index width.
- NUM_WAYS, 4, number of ways. Legal range 1..8.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of sets. Derived, not overridden.

Ports:
- clk0  input  1  clock; all state changes on posedge.
- rst0  input  1  asynchronous reset, active-high.
- csb0  input  1  active-low chip select.
- web0  input  1  active-low write enable; 1 = read.
- wmask0  input  NUM_WAYS  per-way write enable; used on writes only.
- addr0  input  ADDR_WIDTH  set index.
- din0  input  DATA_WIDTH  tag written to every masked way.
- vin0  input  1  valid bit written to every masked way.
- cmp_tag0  input  DATA_WIDTH  tag to compare on a read.
- dout0  output  NUM_WAYS*DATA_WIDTH  tags read out; way w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].
- vout0  output  NUM_WAYS  valid bits read out.
- hit0  output  NUM_WAYS  per-way hit: vout0[w] & (tag_w == cmp_tag0 captured with the request).
- rvalid0  output  1  one-cycle pulse when dout0, vout0 and hit0 carry new read data.
- ready0  output  1  array is accepting requests.

Behaviour:
- Reset: clock clk0, reset rst0, asynchronous, active-high.
  - While rst0=1: FSM = INIT, sweep counter = 0, ready0=0, rvalid0=0, dout0=0, vout0=0, hit0=0.
  - The memory array itself is not reset; the sweep clears it.
- FSM states:
  - INIT: each cycle, writes tag=0 and valid=0 to all ways of set[counter], then counter+1. When counter == RAM_DEPTH-1 is written, the next state is IDLE.
  - The sweep takes exactly RAM_DEPTH cycles after rst0 deasserts (128 by default).
  - IDLE: ready0=1. ready0 is a registered output, so it rises on the posedge that enters IDLE.
- Request acceptance: a request is accepted at a posedge only when csb0=0 and ready0=1.
  - Requests presented while ready0=0 are dropped silently: no write, no rvalid0.
- Write (web0=0):
  - For each w with wmask0[w]=1: tag_w[addr0] <= din0 and valid_w[addr0] <= vin0, committed at the accepting posedge.
  - Unmasked ways are unchanged. wmask0=0 is a legal no-op.
  - rvalid0 stays 0 and the read outputs hold their values.
- Read (web0=1):
  - Latency 1. Outputs are updated on the posedge after acceptance, and rvalid0=1 for that one cycle.
  - cmp_tag0 is sampled with the request.
  - dout0, vout0 and hit0 hold their last values until the next read completes. They never go to X.
  - Back-to-back reads give one result per cycle.
- Ordering:
  - A write at cycle N followed by a read of the same set at N+1 returns the new data.
  - A read at N followed by a write at N+1 returns the old data.
- Multiple hits: hit0 may show more than one way set. Duplicate detection belongs to the controller.
- Reset mid-operation:
  - A pending read result is discarded (rvalid0 forced to 0).
  - The sweep restarts from set 0.
  - A write in flight at reset assertion is not guaranteed.
- Counter width: ADDR_WIDTH bits. The terminal compare is against all-ones, with no wrap into set 0 again.

Optional Feature:
- Macro: MUTATIVE_TAG_FLUSH_EN.
- When defined:
  - Adds input flush0 (1 bit).
  - flush0=1 sampled in IDLE → next state INIT with counter=0, and ready0 drops on that same posedge.
  - A request presented on the same cycle as flush0 is dropped.
  - A read accepted the cycle before still delivers its rvalid0 pulse.
  - flush0 during INIT is ignored; the sweep is not restarted.
  - A flush takes RAM_DEPTH cycles, like the reset sweep.
- When not defined: no flush0 port, and INIT is entered only through rst0.

Test Plan:
- Reset, then idle → ready0=0 for exactly 128 cycles after rst0 falls, then 1. A read of set 0x7F returns vout0=4'b0000, hit0=4'b0000, dout0=0.
- Write addr=0x05, wmask=4'b0100, din=21'h1ABCD, vin=1; next cycle read addr=0x05, cmp_tag=21'h1ABCD → rvalid0 pulses one cycle, vout0=4'b0100, hit0=4'b0100, way2 tag=21'h1ABCD, other ways 0.
- Same set, write wmask=4'b0101, din=21'h00033, vin=1, then read cmp_tag=21'h00033 → hit0=4'b0101; cmp_tag=21'h1ABCD → hit0=4'b0000. Way2 was overwritten.
- Read addr=0x10, then write addr=0x10, wmask=4'b1111, din=21'h7, vin=1, next cycle → read result shows the old contents; a following read shows 21'h7 in all ways with vout0=4'b1111.
- csb0=0, web0=0 while ready0=0 during the sweep → no write takes effect after the sweep; rvalid0 never pulses during the sweep. Assert rst0 mid-sweep at set 0x40 → ready0 stays 0 for a further 128 cycles.
- With MUTATIVE_TAG_FLUSH_EN: fill set 0x22, pulse flush0 → ready0=0 for 128 cycles; a read then gives vout0=4'b0000. A read issued the cycle before flush0 still returns rvalid0=1 with the pre-flush data.

Source files
------------

// File: rtl/mutative_tag_array_nway.sv
// N-way tag array with per-way write mask, registered hit compare and a post-reset clearing sweep.
// Optional macro MUTATIVE_TAG_FLUSH_EN adds a flush0 input that re-runs the clearing sweep from IDLE.
module mutative_tag_array_nway #(
  parameter int DATA_WIDTH = 21,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WAYS   = 4
) (
  input  logic                           clk0,
  input  logic                           rst0,
`ifdef MUTATIVE_TAG_FLUSH_EN
  input  logic                           flush0,
`endif
  input  logic                           csb0,
  input  logic                           web0,
  input  logic [NUM_WAYS-1:0]            wmask0,
  input  logic [ADDR_WIDTH-1:0]          addr0,
  input  logic [DATA_WIDTH-1:0]          din0,
  input  logic                           vin0,
  input  logic [DATA_WIDTH-1:0]          cmp_tag0,
  output logic [NUM_WAYS*DATA_WIDTH-1:0] dout0,
  output logic [NUM_WAYS-1:0]            vout0,
  output logic [NUM_WAYS-1:0]            hit0,
  output logic                           rvalid0,
  output logic                           ready0
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int TW        = NUM_WAYS * DATA_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  function automatic logic [NUM_WAYS-1:0] hit_vec(
    input logic [TW-1:0]         tags,
    input logic [NUM_WAYS-1:0]   valid,
    input logic [DATA_WIDTH-1:0] cmp
  );
    logic [NUM_WAYS-1:0] h;
    h = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      h[w] = valid[w] & (tags[w*DATA_WIDTH +: DATA_WIDTH] == cmp);
    end
    return h;
  endfunction

  logic [DATA_WIDTH-1:0] tag_mem   [RAM_DEPTH][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_mem [RAM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_cmp_q;
  logic                  rvalid_q;
  logic [TW-1:0]         dout_q;
  logic [NUM_WAYS-1:0]   vout_q;
  logic [NUM_WAYS-1:0]   hit_q;

  logic                  flush_s;
  logic                  accept_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [TW-1:0]         rd_tags_s;
  logic [NUM_WAYS-1:0]   rd_valid_s;
  logic [NUM_WAYS-1:0]   rd_hit_s;

`ifdef MUTATIVE_TAG_FLUSH_EN
  assign flush_s = flush0;
`else
  assign flush_s = 1'b0;
`endif

  // A flush in the same cycle wins over any request.
  assign accept_s = ~csb0 & ready_q & ~flush_s;
  assign wr_s     = accept_s & ~web0;
  assign rd_s     = accept_s & web0;

  // Sweep/idle sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
          ready_d = 1'b0;
        end
      end
      ST_IDLE: begin
        if (flush_s) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Array storage: sweep clears a whole set, otherwise masked per-way writes.
  always_ff @(posedge clk0) begin
    if (state_q == ST_INIT) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        tag_mem[cnt_q][w] <= '0;
      end
      valid_mem[cnt_q] <= '0;
    end else if (wr_s) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (wmask0[w]) begin
          tag_mem[addr0][w]   <= din0;
          valid_mem[addr0][w] <= vin0;
        end
      end
    end
  end

  // Array read of the pending set.
  always_comb begin
    rd_tags_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_tags_s[w*DATA_WIDTH +: DATA_WIDTH] = tag_mem[rd_addr_q][w];
    end
    rd_valid_s = valid_mem[rd_addr_q];
    rd_hit_s   = hit_vec(rd_tags_s, rd_valid_s, rd_cmp_q);
  end

  // Read request capture and result registers.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_cmp_q  <= '0;
      rvalid_q  <= 1'b0;
      dout_q    <= '0;
      vout_q    <= '0;
      hit_q     <= '0;
    end else begin
      rd_pend_q <= rd_s;
      if (rd_s) begin
        rd_addr_q <= addr0;
        rd_cmp_q  <= cmp_tag0;
      end
      rvalid_q <= rd_pend_q;
      if (rd_pend_q) begin
        dout_q <= rd_tags_s;
        vout_q <= rd_valid_s;
        hit_q  <= rd_hit_s;
      end
    end
  end

  assign dout0   = dout_q;
  assign vout0   = vout_q;
  assign hit0    = hit_q;
  assign rvalid0 = rvalid_q;
  assign ready0  = ready_q;

endmodule

// File: tb/tb_mutative_tag_array_nway.sv
// Directed bench for mutative_tag_array_nway (default 21-bit tags, 128 sets, 4 ways).
module tb_mutative_tag_array_nway;

  logic        clk0;
  logic        rst0;
`ifdef MUTATIVE_TAG_FLUSH_EN
  logic        flush0;
`endif
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [6:0]  addr0;
  logic [20:0] din0;
  logic        vin0;
  logic [20:0] cmp_tag0;
  logic [83:0] dout0;
  logic [3:0]  vout0;
  logic [3:0]  hit0;
  logic        rvalid0;
  logic        ready0;

  int checks;
  int failures;
  int n;
  logic sweep_rv;

  mutative_tag_array_nway dut (
    .clk0     (clk0),
    .rst0     (rst0),
`ifdef MUTATIVE_TAG_FLUSH_EN
    .flush0   (flush0),
`endif
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .vin0     (vin0),
    .cmp_tag0 (cmp_tag0),
    .dout0    (dout0),
    .vout0    (vout0),
    .hit0     (hit0),
    .rvalid0  (rvalid0),
    .ready0   (ready0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [3:0] m, input logic [20:0] d, input logic v);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; wmask0 = m; din0 = d; vin0 = v;
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic rd(input logic [6:0] a, input logic [20:0] c);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; cmp_tag0 = c;
    @(negedge clk0);
    csb0 = 1'b1;
    chk("rd_wait", {127'd0, rvalid0}, 128'd0);
    @(negedge clk0);
    chk("rd_pulse", {127'd0, rvalid0}, 128'd1);
  endtask

  // Counts negedges until ready0 rises, bounded.
  task automatic count_ready(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk0);
      cnt++;
    end while (!ready0 && cnt < 400);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 7'h00;
    din0 = 21'h0; vin0 = 1'b0; cmp_tag0 = 21'h0;
`ifdef MUTATIVE_TAG_FLUSH_EN
    flush0 = 1'b0;
`endif
    repeat (3) @(negedge clk0);
    chk("rst_ready", {127'd0, ready0}, 128'd0);
    chk("rst_rvalid", {127'd0, rvalid0}, 128'd0);
    chk("rst_dout", {44'd0, dout0}, 128'd0);
    chk("rst_vout_hit", {120'd0, vout0, hit0}, 128'd0);

    // Initial sweep while hammering requests that must be dropped.
    rst0 = 1'b0;
    n = 0; sweep_rv = 1'b0;
    do begin
      if (n < 120) begin
        csb0 = 1'b0; web0 = n[0]; addr0 = 7'h33; wmask0 = 4'hF; din0 = 21'h1FFFF; vin0 = 1'b1;
        cmp_tag0 = 21'h1FFFF;
      end else begin
        csb0 = 1'b1;
      end
      @(negedge clk0);
      n++;
      if (rvalid0) sweep_rv = 1'b1;
    end while (!ready0 && n < 400);
    csb0 = 1'b1; web0 = 1'b1;
    chk("sweep_len", 128'(n), 128'd128);
    chk("sweep_no_rvalid", {127'd0, sweep_rv}, 128'd0);

    rd(7'h7F, 21'h0);
    chk("clr7f_vout", {124'd0, vout0}, 128'd0);
    chk("clr7f_hit", {124'd0, hit0}, 128'd0);
    chk("clr7f_dout", {44'd0, dout0}, 128'd0);
    rd(7'h33, 21'h1FFFF);
    chk("drop_wr_vout", {124'd0, vout0}, 128'd0);
    chk("drop_wr_dout", {44'd0, dout0}, 128'd0);

    // Single-way write then immediate read.
    wr(7'h05, 4'b0100, 21'h1ABCD, 1'b1);
    rd(7'h05, 21'h1ABCD);
    chk("w2_vout", {124'd0, vout0}, 128'h4);
    chk("w2_hit", {124'd0, hit0}, 128'h4);
    chk("w2_dout", {44'd0, dout0}, {44'd0, 21'h0, 21'h1ABCD, 21'h0, 21'h0});
    @(negedge clk0);
    chk("rvalid_one_cycle", {127'd0, rvalid0}, 128'd0);

    // Two-way overwrite, multiple hits.
    wr(7'h05, 4'b0101, 21'h00033, 1'b1);
    rd(7'h05, 21'h00033);
    chk("w02_hit", {124'd0, hit0}, 128'h5);
    chk("w02_vout", {124'd0, vout0}, 128'h5);
    chk("w02_dout", {44'd0, dout0}, {44'd0, 21'h0, 21'h00033, 21'h0, 21'h00033});
    rd(7'h05, 21'h1ABCD);
    chk("old_tag_miss", {124'd0, hit0}, 128'h0);

    // Invalidating write: tag matches but valid is 0.
    wr(7'h05, 4'b0001, 21'h12345, 1'b0);
    rd(7'h05, 21'h12345);
    chk("inv_hit", {124'd0, hit0}, 128'h0);
    chk("inv_vout", {124'd0, vout0}, 128'h4);
    chk("inv_dout", {44'd0, dout0}, {44'd0, 21'h0, 21'h00033, 21'h0, 21'h12345});
    rd(7'h05, 21'h00033);
    chk("inv_hit_w2", {124'd0, hit0}, 128'h4);

    // Read followed by write to the same set returns old data.
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'h10; cmp_tag0 = 21'h7;
    @(negedge clk0);
    web0 = 1'b0; wmask0 = 4'hF; din0 = 21'h7; vin0 = 1'b1;
    chk("rw_wait", {127'd0, rvalid0}, 128'd0);
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1;
    chk("rw_pulse", {127'd0, rvalid0}, 128'd1);
    chk("rw_old_dout", {44'd0, dout0}, 128'd0);
    chk("rw_old_vout", {124'd0, vout0}, 128'd0);
    rd(7'h10, 21'h7);
    chk("rw_new_dout", {44'd0, dout0}, {44'd0, 21'h7, 21'h7, 21'h7, 21'h7});
    chk("rw_new_vout_hit", {120'd0, vout0, hit0}, 128'hFF);

    // A write leaves the read outputs untouched.
    wr(7'h10, 4'b0001, 21'h0, 1'b0);
    chk("hold_rvalid", {127'd0, rvalid0}, 128'd0);
    chk("hold_dout", {44'd0, dout0}, {44'd0, 21'h7, 21'h7, 21'h7, 21'h7});
    chk("hold_hit", {124'd0, hit0}, 128'hF);

    // Reset with a read pending discards the result and re-sweeps.
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'h05; cmp_tag0 = 21'h00033;
    @(negedge clk0);
    csb0 = 1'b1;
    rst0 = 1'b1;
    @(negedge clk0);
    chk("pend_discard", {127'd0, rvalid0}, 128'd0);
    chk("pend_dout_rst", {44'd0, dout0}, 128'd0);
    rst0 = 1'b0;
    count_ready(n);
    chk("resweep_len", 128'(n), 128'd128);
    rd(7'h05, 21'h00033);
    chk("resweep_clr05", {124'd0, vout0, hit0[3:0] & 4'h0} | {124'd0, hit0}, 128'h0);
    rd(7'h10, 21'h7);
    chk("resweep_clr10", {44'd0, dout0}, 128'd0);

    // Reset mid-sweep at set 0x40 restarts the full sweep.
    rst0 = 1'b1;
    @(negedge clk0);
    rst0 = 1'b0;
    repeat (64) @(negedge clk0);
    chk("mid_sweep_busy", {127'd0, ready0}, 128'd0);
    rst0 = 1'b1;
    @(negedge clk0);
    rst0 = 1'b0;
    count_ready(n);
    chk("mid_restart_len", 128'(n), 128'd128);

`ifdef MUTATIVE_TAG_FLUSH_EN
    wr(7'h22, 4'hF, 21'h155, 1'b1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'h22; cmp_tag0 = 21'h155;
    @(negedge clk0);
    flush0 = 1'b1; web0 = 1'b0; wmask0 = 4'hF; din0 = 21'h3; vin0 = 1'b1;
    chk("fl_wait", {127'd0, rvalid0}, 128'd0);
    @(negedge clk0);
    flush0 = 1'b0; csb0 = 1'b1; web0 = 1'b1;
    chk("fl_pre_pulse", {127'd0, rvalid0}, 128'd1);
    chk("fl_pre_vout_hit", {120'd0, vout0, hit0}, 128'hFF);
    chk("fl_pre_dout", {44'd0, dout0}, {44'd0, 21'h155, 21'h155, 21'h155, 21'h155});
    chk("fl_ready_drop", {127'd0, ready0}, 128'd0);
    n = 0;
    do begin
      flush0 = (n == 10);
      @(negedge clk0);
      n++;
    end while (!ready0 && n < 400);
    flush0 = 1'b0;
    chk("fl_len", 128'(n), 128'd128);
    rd(7'h22, 21'h155);
    chk("fl_clr_vout", {124'd0, vout0}, 128'd0);
    chk("fl_clr_hit", {124'd0, hit0}, 128'd0);
    chk("fl_clr_dout", {44'd0, dout0}, 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
